// File: rtl/alu_cmd_issuer_pkg.sv
// alu_cmd_issuer_pkg: opcodes, FSM states and opcode validity check shared by the issuer slice.
package alu_cmd_issuer_pkg;
    localparam int DEF_WIDTH = 8;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_EQ   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_XNOR = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    function automatic logic op_is_valid(input logic [3:0] op);
        return op <= OP_AND;
    endfunction
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command, response and ALU operand/result bundle; master is the issuer side.
interface alu_cmd_issuer_if
    import alu_cmd_issuer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = 4
);
    logic             cmd_valid, cmd_ready;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [3:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [3:0]       alu_opcode;
    logic             alu_zero, alu_carry;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_carry, rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, alu_zero, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err, rsp_tag
    );
    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, alu_zero, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues one ALU command at a time, waits ALU_LAT cycles, returns a tagged response.
// Unsupported opcodes and divide-by-zero are answered with rsp_err without touching the ALU inputs.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_issuer_if.master   bus,
    output logic               busy,
    output logic [15:0]        op_count
);
    localparam int CW = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic             zero_q, zero_d, carry_q, carry_d, err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      ops_q, ops_d;
    logic             reject;
    assign reject = !op_is_valid(bus.cmd_op) || (bus.cmd_op == OP_DIV && bus.cmd_b == '0);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        err_d   = err_q;
        tag_d   = tag_q;
        ops_d   = ops_q;
        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                tag_d = bus.cmd_tag;
                if (reject) begin
                    state_d = S_RESP;
                    res_d   = '0;
                    zero_d  = 1'b0;
                    carry_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    alu_a_d = bus.cmd_a;
                    alu_b_d = bus.cmd_b;
                    op_d    = bus.cmd_op;
                    cnt_d   = CW'(ALU_LAT);
                end
            end
            S_WAIT: if (cnt_q == '0) begin
                state_d = S_RESP;
                res_d   = bus.alu_result;
                zero_d  = bus.alu_zero;
                carry_d = bus.alu_carry;
                err_d   = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            S_RESP: if (bus.rsp_ready) begin
                state_d = S_IDLE;
                ops_d   = ops_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            ops_q   <= ops_d;
        end
    end
    assign bus.cmd_ready  = state_q == S_IDLE;
    assign busy           = state_q != S_IDLE;
    assign bus.rsp_valid  = state_q == S_RESP;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = op_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_err    = err_q;
    assign bus.rsp_tag    = tag_q;
    assign op_count       = ops_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: two issuers (ALU_LAT 0 and 3) against a transaction-level model, directed then random.
module tb_alu_cmd_issuer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst [2];
    logic        cv [2], rr [2];
    logic [7:0]  ca [2], cb [2];
    logic [3:0]  cop [2], ctag [2];
    logic        rdy [2], bsy [2], vld [2], rz [2], rc [2], rerr [2];
    logic [7:0]  rres [2], aa [2], ab [2];
    logic [3:0]  aop [2], rtag [2];
    logic [15:0] opc [2];
    int n_cmp = 0, n_bad = 0;
    bit chk_on = 0;

    function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] s;
        logic [15:0] p;
        logic [7:0] r;
        logic c;
        s = '0;
        p = a * b;
        r = '0;
        c = 1'b0;
        case (op)
            4'd0: begin s = a + b; r = s[7:0]; c = s[8]; end
            4'd1: begin s = a - b; r = s[7:0]; c = s[8]; end
            4'd2: begin r = p[7:0]; c = |p[15:8]; end
            4'd3: r = (b == 0) ? 8'd0 : a / b;
            4'd4: r = {7'd0, a == b};
            4'd5: r = a ^ b;
            4'd6: r = ~(a ^ b);
            4'd7: r = a & b;
            default: r = '0;
        endcase
        return {c, r == 8'd0, r};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        alu_cmd_issuer_if #(.WIDTH(8), .TAG_W(4)) bus ();
        alu_cmd_issuer #(.WIDTH(8), .ALU_LAT(3 * g), .TAG_W(4)) dut (
            .clk(clk), .rst(rst[g]), .bus(bus), .busy(bsy[g]), .op_count(opc[g])
        );
        assign bus.cmd_valid = cv[g];
        assign bus.cmd_a     = ca[g];
        assign bus.cmd_b     = cb[g];
        assign bus.cmd_op    = cop[g];
        assign bus.cmd_tag   = ctag[g];
        assign bus.rsp_ready = rr[g];
        assign {bus.alu_carry, bus.alu_zero, bus.alu_result} = alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);
        assign rdy[g]  = bus.cmd_ready;
        assign vld[g]  = bus.rsp_valid;
        assign rres[g] = bus.rsp_result;
        assign rz[g]   = bus.rsp_zero;
        assign rc[g]   = bus.rsp_carry;
        assign rerr[g] = bus.rsp_err;
        assign rtag[g] = bus.rsp_tag;
        assign aa[g]   = bus.alu_a;
        assign ab[g]   = bus.alu_b;
        assign aop[g]  = bus.alu_opcode;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a command in flight becomes visible once edge count reaches m_rdy.
    int          e = 0;
    bit          m_inf [2];
    int          m_rdy [2];
    logic [7:0]  m_res [2], m_aa [2], m_ab [2];
    logic [3:0]  m_aop [2], m_tag [2];
    logic        m_z [2], m_c [2], m_err [2];
    logic [15:0] m_cnt [2];
    always @(posedge clk) begin
        e++;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_inf[i] = 0;
                m_cnt[i] = 0;
                m_aa[i]  = 0;
                m_ab[i]  = 0;
                m_aop[i] = 0;
            end else if (m_inf[i]) begin
                if (e - 1 >= m_rdy[i] && rr[i]) begin
                    m_inf[i] = 0;
                    m_cnt[i]++;
                end
            end else if (cv[i]) begin
                m_inf[i] = 1;
                m_tag[i] = ctag[i];
                if (cop[i] > 4'd7 || (cop[i] == 4'd3 && cb[i] == 8'd0)) begin
                    m_rdy[i] = e;
                    {m_c[i], m_z[i], m_res[i]} = 10'd0;
                    m_err[i] = 1;
                end else begin
                    m_rdy[i] = e + 3 * i + 1;
                    m_aa[i]  = ca[i];
                    m_ab[i]  = cb[i];
                    m_aop[i] = cop[i];
                    {m_c[i], m_z[i], m_res[i]} = alu_f(ca[i], cb[i], cop[i]);
                    m_err[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                bit v;
                v = m_inf[i] && e >= m_rdy[i];
                chk($sformatf("cmd_ready%0d", i), rdy[i], !m_inf[i]);
                chk($sformatf("busy%0d", i), bsy[i], m_inf[i]);
                chk($sformatf("rsp_valid%0d", i), vld[i], v);
                chk($sformatf("op_count%0d", i), opc[i], m_cnt[i]);
                chk($sformatf("alu_ops%0d", i), {aa[i], ab[i], aop[i]}, {m_aa[i], m_ab[i], m_aop[i]});
                if (v) begin
                    chk($sformatf("rsp_result%0d", i), rres[i], m_res[i]);
                    chk($sformatf("rsp_flags%0d", i), {rz[i], rc[i], rerr[i]}, {m_z[i], m_c[i], m_err[i]});
                    chk($sformatf("rsp_tag%0d", i), rtag[i], m_tag[i]);
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [3:0] t);
        int k = 0;
        @(negedge clk);
        cv[i] = 1; ca[i] = a; cb[i] = b; cop[i] = op; ctag[i] = t;
        while (!rdy[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("accept%0d", i), k < 40, 1);
        @(posedge clk);
        #1 cv[i] = 0;
    endtask

    // Called right after the accepting edge; lat is the number of edges until rsp_valid shows.
    task automatic get_rsp(input int i, input int lat, input logic [7:0] r, input logic z, input logic c,
                           input logic er, input logic [3:0] t, input int hold);
        int k = 0;
        @(negedge clk);
        while (!vld[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_latency", k, lat);
        chk("lit_result", rres[i], r);
        chk("lit_flags", {rz[i], rc[i], rerr[i]}, {z, c, er});
        chk("lit_tag", rtag[i], t);
        for (int h = 0; h < hold; h++) begin
            chk("hold_result", rres[i], r);
            chk("hold_ready", rdy[i], 0);
            @(negedge clk);
        end
        rr[i] = 1;
        @(posedge clk);
        #1 rr[i] = 0;
    endtask

    initial begin
        logic [7:0] a, b;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; cv[i] = 0; rr[i] = 0; ca[i] = 0; cb[i] = 0; cop[i] = 0; ctag[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 0; rst[1] = 0;
        chk_on = 1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", rdy[i], 1);
            chk("reset_valid", vld[i], 0);
            chk("reset_opc", opc[i], 0);
            chk("reset_alu_a", aa[i], 0);
        end
        send(0, 8'd5, 8'd3, 4'd0, 4'd3);
        get_rsp(0, 1, 8'd8, 0, 0, 0, 4'd3, 0);
        chk("opc_t1", opc[0], 1);
        send(0, 8'd10, 8'd7, 4'd1, 4'd4);
        cv[0] = 1; ca[0] = 8'd2; cb[0] = 8'd2; cop[0] = 4'd0; ctag[0] = 4'd5;
        get_rsp(0, 1, 8'd3, 0, 0, 0, 4'd4, 5);
        @(negedge clk);
        chk("post_hs_valid", vld[0], 0);
        chk("post_hs_ready", rdy[0], 1);
        @(posedge clk);
        #1 cv[0] = 0;
        get_rsp(0, 1, 8'd4, 0, 0, 0, 4'd5, 0);
        send(0, 8'd1, 8'd2, 4'b1010, 4'd6);
        chk("noissue_alu", {aa[0], ab[0], aop[0]}, {8'd2, 8'd2, 4'd0});
        get_rsp(0, 0, 8'd0, 0, 0, 1, 4'd6, 0);
        chk("opc_t3", opc[0], 4);
        send(0, 8'd10, 8'd0, 4'd3, 4'd7);
        get_rsp(0, 0, 8'd0, 0, 0, 1, 4'd7, 0);
        send(0, 8'd10, 8'd2, 4'd3, 4'd8);
        get_rsp(0, 1, 8'd5, 0, 0, 0, 4'd8, 0);
        send(0, 8'd10, 8'd15, 4'd5, 4'd9);
        get_rsp(0, 1, 8'd5, 0, 0, 0, 4'd9, 0);
        send(0, 8'd10, 8'd5, 4'd7, 4'd10);
        get_rsp(0, 1, 8'd0, 1, 0, 0, 4'd10, 0);
        chk("opc_t5", opc[0], 8);
        send(1, 8'd2, 8'd3, 4'd0, 4'd2);
        get_rsp(1, 4, 8'd5, 0, 0, 0, 4'd2, 0);
        chk("opc_lat3", opc[1], 1);
        send(1, 8'd4, 8'd4, 4'd0, 4'd1);
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1;
        @(negedge clk);
        rst[1] = 0;
        chk("midrst_ready", rdy[1], 1);
        chk("midrst_valid", vld[1], 0);
        chk("midrst_opc", opc[1], 0);
        chk("midrst_alu", {aa[1], ab[1], aop[1]}, 0);
        send(1, 8'd1, 8'd1, 4'd0, 4'd3);
        get_rsp(1, 4, 8'd2, 0, 0, 0, 4'd3, 0);
        for (int i = 0; i < 2; i++) begin
            repeat (60) begin
                int k;
                a = 8'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                send(i, a, b, 4'($urandom), 4'($urandom));
                if ($urandom_range(0, 15) == 0) begin
                    @(negedge clk);
                    rst[i] = 1;
                    @(negedge clk);
                    rst[i] = 0;
                end else begin
                    k = 0;
                    forever begin
                        @(negedge clk);
                        rr[i] = 1'($urandom); cv[i] = 1'($urandom);
                        ca[i] = 8'($urandom); cb[i] = 8'($urandom); cop[i] = 4'($urandom); ctag[i] = 4'($urandom);
                        if ((vld[i] && rr[i]) || k == 60) break;
                        k++;
                    end
                    chk("rsp_wait", k < 60, 1);
                    @(posedge clk);
                    #1 rr[i] = 0; cv[i] = 0;
                end
            end
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
